// File: rtl/uart_alu_interface_pkg.sv
// Shared state encoding and ALU opcode constants for the UART/ALU sequencer.
package uart_alu_interface_pkg;

    typedef enum logic [2:0] {
        ST_WAIT_A  = 3'd0,
        ST_WAIT_B  = 3'd1,
        ST_WAIT_OP = 3'd2,
        ST_EXEC    = 3'd3,
        ST_SEND    = 3'd4,
        ST_WAIT_TX = 3'd5
    } state_t;

    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_SRA = 6'b000011;
    localparam logic [5:0] OP_SRL = 6'b000010;
    localparam logic [5:0] OP_NOR = 6'b100111;

endpackage

// File: rtl/uart_alu_interface_if.sv
// Signal bundle between the sequencer (slave) and the UART/ALU side (master).
interface uart_alu_interface_if #(
    parameter int NB_DATA   = 8,
    parameter int NB_OPCODE = 6
);
    logic                 i_tick;
    logic                 i_rx_done;
    logic [NB_DATA-1:0]   i_rx_data;
    logic                 i_tx_done;
    logic [NB_DATA-1:0]   i_alu_result;
    logic [NB_DATA-1:0]   o_alu_data_a;
    logic [NB_DATA-1:0]   o_alu_data_b;
    logic [NB_OPCODE-1:0] o_alu_opcode;
    logic                 o_tx_start;
    logic [NB_DATA-1:0]   o_tx_data;
    logic                 o_busy;
    logic                 o_error;

    modport slave (
        input  i_tick, i_rx_done, i_rx_data, i_tx_done, i_alu_result,
        output o_alu_data_a, o_alu_data_b, o_alu_opcode,
        output o_tx_start, o_tx_data, o_busy, o_error
    );

    modport master (
        output i_tick, i_rx_done, i_rx_data, i_tx_done, i_alu_result,
        input  o_alu_data_a, o_alu_data_b, o_alu_opcode,
        input  o_tx_start, o_tx_data, o_busy, o_error
    );
endinterface

// File: rtl/uart_alu_interface.sv
// Frame sequencer: A, B, opcode bytes -> ALU -> UART transmit.
// Define INTERFACE_TIMEOUT_EN to abort partial frames after TIMEOUT_TICKS ticks.
module uart_alu_interface
    import uart_alu_interface_pkg::*;
#(
    parameter int          NB_DATA       = 8,
    parameter int          NB_OPCODE     = 6,
    parameter int unsigned TIMEOUT_TICKS = 1024
) (
    input  logic clk,
    input  logic rst_n,
    uart_alu_interface_if.slave bus
);

    state_t               state;
    logic [NB_DATA-1:0]   data_a;
    logic [NB_DATA-1:0]   data_b;
    logic [NB_DATA-1:0]   tx_data;
    logic [NB_OPCODE-1:0] opcode;
    logic                 tx_start;
    logic                 error;
    logic                 timeout;

`ifdef INTERFACE_TIMEOUT_EN
    logic [15:0] tmo_cnt;
    logic        waiting;

    assign waiting = (state == ST_WAIT_B) || (state == ST_WAIT_OP);
    assign timeout = waiting && (tmo_cnt == 16'(TIMEOUT_TICKS));

    // Held at zero outside a partial frame, so WAIT_A entry always sees a clear count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else if (!waiting || bus.i_rx_done || timeout) begin
            tmo_cnt <= '0;
        end else if (bus.i_tick) begin
            tmo_cnt <= tmo_cnt + 16'd1;
        end
    end
`else
    logic unused_cfg;

    assign timeout    = 1'b0;
    assign unused_cfg = bus.i_tick ^ TIMEOUT_TICKS[0];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_WAIT_A;
            data_a   <= '0;
            data_b   <= '0;
            opcode   <= '0;
            tx_data  <= '0;
            tx_start <= 1'b0;
            error    <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            error    <= 1'b0;
            unique case (state)
                ST_WAIT_A: begin
                    if (bus.i_rx_done) begin
                        data_a <= bus.i_rx_data;
                        state  <= ST_WAIT_B;
                    end
                end
                ST_WAIT_B: begin
                    if (bus.i_rx_done) begin
                        data_b <= bus.i_rx_data;
                        state  <= ST_WAIT_OP;
                    end else if (timeout) begin
                        error <= 1'b1;
                        state <= ST_WAIT_A;
                    end
                end
                ST_WAIT_OP: begin
                    if (bus.i_rx_done) begin
                        opcode <= bus.i_rx_data[NB_OPCODE-1:0];
                        state  <= ST_EXEC;
                    end else if (timeout) begin
                        error <= 1'b1;
                        state <= ST_WAIT_A;
                    end
                end
                ST_EXEC: begin
                    // Start is raised here so it is visible during SEND
                    tx_data  <= bus.i_alu_result;
                    tx_start <= 1'b1;
                    state    <= ST_SEND;
                end
                ST_SEND: begin
                    state <= ST_WAIT_TX;
                end
                ST_WAIT_TX: begin
                    if (bus.i_tx_done) begin
                        state <= ST_WAIT_A;
                    end
                end
                default: begin
                    state <= ST_WAIT_A;
                end
            endcase
        end
    end

    assign bus.o_alu_data_a = data_a;
    assign bus.o_alu_data_b = data_b;
    assign bus.o_alu_opcode = opcode;
    assign bus.o_tx_data    = tx_data;
    assign bus.o_tx_start   = tx_start;
    assign bus.o_error      = error;
    assign bus.o_busy       = (state != ST_WAIT_A);

endmodule

// File: tb/tb_uart_alu_interface.sv
// Randomized bench for uart_alu_interface with a frame-level reference model.
module tb_uart_alu_interface;
    import uart_alu_interface_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    int checks = 0;
    int errors = 0;
    int start_pulses = 0;
    int error_pulses = 0;
    int exp_starts = 0;
    int exp_errors = 0;

    logic [7:0] last_a = 8'h00;
    logic [7:0] last_b = 8'h00;
    logic [7:0] last_tx = 8'h00;
    logic [5:0] last_op = 6'h00;

    logic [5:0] ops [8] = '{OP_ADD, OP_SUB, OP_AND, OP_OR,
                            OP_XOR, OP_SRA, OP_SRL, OP_NOR};

    uart_alu_interface_if #(.NB_DATA(8), .NB_OPCODE(6)) bus ();

    uart_alu_interface #(
        .NB_DATA(8),
        .NB_OPCODE(6),
        .TIMEOUT_TICKS(16)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_ref(input logic [5:0] op,
                                           input logic [7:0] a,
                                           input logic [7:0] b);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_SRA:  return 8'($signed(a) >>> b[2:0]);
            OP_SRL:  return a >> b[2:0];
            OP_NOR:  return ~(a | b);
            default: return 8'h00;
        endcase
    endfunction

    assign bus.i_alu_result = alu_ref(bus.o_alu_opcode, bus.o_alu_data_a,
                                      bus.o_alu_data_b);

    always @(negedge clk) begin
        if (bus.o_tx_start === 1'b1) start_pulses++;
        if (bus.o_error === 1'b1) error_pulses++;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input bit noisy);
        for (int i = 0; i < n; i++) begin
            bus.i_tick    = noisy ? 1'($urandom) : 1'b0;
            bus.i_tx_done = noisy ? ($urandom_range(3) == 0) : 1'b0;
            step();
        end
        bus.i_tick    = 1'b0;
        bus.i_tx_done = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.i_rx_data = b;
        bus.i_rx_done = 1'b1;
        step();
        bus.i_rx_done = 1'b0;
        bus.i_rx_data = 8'($urandom);
    endtask

    task automatic complete_frame(input logic [7:0] opb);
        send_byte(opb);
        last_op = opb[5:0];
        check("opcode", bus.o_alu_opcode, last_op);
        check("exec_no_start", bus.o_tx_start, 1'b0);
        check("exec_busy", bus.o_busy, 1'b1);
        step();
        last_tx = alu_ref(last_op, last_a, last_b);
        exp_starts++;
        check("send_start", bus.o_tx_start, 1'b1);
        check("tx_data", bus.o_tx_data, last_tx);
        step();
        check("wait_tx_start_low", bus.o_tx_start, 1'b0);
        check("wait_tx_busy", bus.o_busy, 1'b1);
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] opb, input bit noisy);
        send_byte(a);
        last_a = a;
        check("data_a", bus.o_alu_data_a, last_a);
        check("wait_b_busy", bus.o_busy, 1'b1);
        idle(noisy ? int'($urandom_range(3)) : 0, noisy);
        check("wait_b_hold", bus.o_busy, 1'b1);
        send_byte(b);
        last_b = b;
        check("data_b", bus.o_alu_data_b, last_b);
        check("data_a_hold", bus.o_alu_data_a, last_a);
        idle(noisy ? int'($urandom_range(3)) : 0, noisy);
        complete_frame(opb);
    endtask

    task automatic finish_tx(input int delay, input bit junk);
        for (int i = 0; i < delay; i++) step();
        if (junk) begin
            send_byte(8'hAA);
            check("junk_a", bus.o_alu_data_a, last_a);
            check("junk_b", bus.o_alu_data_b, last_b);
            check("junk_op", bus.o_alu_opcode, last_op);
            check("junk_busy", bus.o_busy, 1'b1);
        end
        bus.i_tx_done = 1'b1;
        step();
        bus.i_tx_done = 1'b0;
        check("idle_after_tx", bus.o_busy, 1'b0);
        check("tx_data_held", bus.o_tx_data, last_tx);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] opb;
        bus.i_tick    = 1'b0;
        bus.i_rx_done = 1'b0;
        bus.i_rx_data = 8'h00;
        bus.i_tx_done = 1'b0;

        repeat (4) @(posedge clk);
        #1;
        check("rst_a", bus.o_alu_data_a, 8'h00);
        check("rst_b", bus.o_alu_data_b, 8'h00);
        check("rst_op", bus.o_alu_opcode, 6'h00);
        check("rst_tx_data", bus.o_tx_data, 8'h00);
        check("rst_start", bus.o_tx_start, 1'b0);
        check("rst_busy", bus.o_busy, 1'b0);
        check("rst_error", bus.o_error, 1'b0);
        @(negedge clk) rst_n = 1'b1;
        step();

        send_frame(8'h05, 8'h50, 8'h65, 1'b0);
        check("or_opcode", bus.o_alu_opcode, 6'b100101);
        check("or_result", bus.o_tx_data, 8'h55);
        finish_tx(3, 1'b0);

        send_frame(8'h03, 8'h04, 8'h20, 1'b0);
        check("add_result", bus.o_tx_data, 8'h07);
        finish_tx(0, 1'b0);
        send_frame(8'hFF, 8'h01, 8'h20, 1'b0);
        check("add_wrap", bus.o_tx_data, 8'h00);
        finish_tx(2, 1'b1);

        send_frame(8'h0F, 8'hF0, 8'h24, 1'b0);
        check("and_result", bus.o_tx_data, 8'h00);
        finish_tx(1, 1'b0);

`ifdef INTERFACE_TIMEOUT_EN
        send_byte(8'h12);
        last_a = 8'h12;
        bus.i_tick = 1'b1;
        repeat (16) step();
        bus.i_tick = 1'b0;
        check("to_pre_busy", bus.o_busy, 1'b1);
        check("to_pre_error", bus.o_error, 1'b0);
        step();
        exp_errors++;
        check("to_error", bus.o_error, 1'b1);
        check("to_idle", bus.o_busy, 1'b0);
        step();
        check("to_error_once", bus.o_error, 1'b0);
        check("to_a_held", bus.o_alu_data_a, 8'h12);
        send_frame(8'h01, 8'h02, 8'h22, 1'b0);
        check("sub_result", bus.o_tx_data, 8'hFF);
        finish_tx(0, 1'b0);

        send_byte(8'h40);
        last_a = 8'h40;
        bus.i_tick = 1'b1;
        repeat (16) step();
        bus.i_rx_data = 8'h41;
        bus.i_rx_done = 1'b1;
        step();
        bus.i_rx_done = 1'b0;
        bus.i_tick = 1'b0;
        last_b = 8'h41;
        check("race_error", bus.o_error, 1'b0);
        check("race_busy", bus.o_busy, 1'b1);
        check("race_b", bus.o_alu_data_b, 8'h41);
        bus.i_tick = 1'b1;
        repeat (15) step();
        bus.i_tick = 1'b0;
        step();
        check("race_cleared", bus.o_error, 1'b0);
        check("race_busy2", bus.o_busy, 1'b1);
        complete_frame({2'b00, OP_ADD});
        check("race_result", bus.o_tx_data, 8'h81);
        finish_tx(0, 1'b0);
`else
        send_byte(8'h12);
        last_a = 8'h12;
        bus.i_tick = 1'b1;
        repeat (40) step();
        bus.i_tick = 1'b0;
        check("nto_busy", bus.o_busy, 1'b1);
        check("nto_error", bus.o_error, 1'b0);
        send_byte(8'h34);
        last_b = 8'h34;
        complete_frame({2'b00, OP_XOR});
        check("nto_result", bus.o_tx_data, 8'h26);
        finish_tx(0, 1'b0);
`endif

        send_byte(8'h11);
        send_byte(8'h22);
        #2 rst_n = 1'b0;
        #1;
        check("mrst_a", bus.o_alu_data_a, 8'h00);
        check("mrst_b", bus.o_alu_data_b, 8'h00);
        check("mrst_op", bus.o_alu_opcode, 6'h00);
        check("mrst_tx_data", bus.o_tx_data, 8'h00);
        check("mrst_start", bus.o_tx_start, 1'b0);
        check("mrst_busy", bus.o_busy, 1'b0);
        check("mrst_error", bus.o_error, 1'b0);
        last_a = 8'h00;
        last_b = 8'h00;
        last_op = 6'h00;
        last_tx = 8'h00;
        repeat (3) step();
        @(negedge clk) rst_n = 1'b1;
        repeat (10) step();
        check("mrst_idle", bus.o_busy, 1'b0);
        check("mrst_no_start", start_pulses, exp_starts);

        for (int n = 0; n < 150; n++) begin
            opb = {2'($urandom),
                   ($urandom_range(7) == 0) ? 6'($urandom)
                                            : ops[$urandom_range(7)]};
            idle(int'($urandom_range(2)), 1'b1);
            send_frame(8'($urandom), 8'($urandom), opb, 1'b1);
            finish_tx(int'($urandom_range(4)), $urandom_range(3) == 0);
        end

        step();
        check("start_count", start_pulses, exp_starts);
        check("error_count", error_pulses, exp_errors);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_alu_interface.md
# uart_alu_interface

Sequencer between the UART receiver/transmitter and the combinational ALU in the UART-ALU top level. Collects three received bytes in order: operand A, operand B, opcode. Presents them to the ALU, captures the result and hands it to the UART transmitter, then waits for transmission to finish before accepting a new frame. Optionally aborts a partial frame after an inter-byte timeout measured in baud ticks.

## Interface
- NB_DATA, 8, width of operands, result and UART bytes
- NB_OPCODE, 6, ALU opcode width; opcode is the low NB_OPCODE bits of the third byte
- TIMEOUT_TICKS, 1024, baud ticks allowed between bytes of one frame (timeout build only); range 1..65535
- clock  in  1  single system clock, rising edge
- reset  in  1  asynchronous, active-low; clears all state
- i_tick  in  1  baud-rate tick from the UART baud generator, one-cycle pulse
- i_rx_done  in  1  one-cycle pulse: i_rx_data holds a new byte
- i_rx_data  in  NB_DATA  received byte, valid while i_rx_done=1
- i_tx_done  in  1  one-cycle pulse: transmitter finished the stop bit
- i_alu_result  in  NB_DATA  combinational ALU output
- o_alu_data_a  out  NB_DATA  registered operand A
- o_alu_data_b  out  NB_DATA  registered operand B
- o_alu_opcode  out  NB_OPCODE  registered opcode
- o_tx_start  out  1  one-cycle pulse requesting transmission of o_tx_data
- o_tx_data  out  NB_DATA  registered ALU result, stable from o_tx_start until next frame's EXEC
- o_busy  out  1  high in every state except WAIT_A
- o_error  out  1  one-cycle pulse on inter-byte timeout (tied 0 without timeout build)

## Operation
- States: WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND, WAIT_TX.
- WAIT_A: i_rx_done -> latch o_alu_data_a, go WAIT_B.
- WAIT_B: i_rx_done -> latch o_alu_data_b, go WAIT_OP.
- WAIT_OP: i_rx_done -> latch o_alu_opcode = i_rx_data[NB_OPCODE-1:0], go EXEC.
- EXEC: one cycle; operands and opcode are stable at ALU input. Latch o_tx_data <= i_alu_result, go SEND.
- SEND: o_tx_start=1 for exactly this cycle, go WAIT_TX.
- WAIT_TX: i_tx_done -> WAIT_A. Stays indefinitely otherwise.
- i_rx_done in EXEC, SEND or WAIT_TX: byte discarded, no state or register change.
- Operand/opcode registers hold their values across frames until overwritten; they are never cleared except by reset.
- Reset (any time, including mid-frame or mid-transmission): state WAIT_A; o_alu_data_a/b, o_alu_opcode, o_tx_data = 0; o_tx_start, o_busy, o_error = 0; timeout counter = 0.

## Timing
- Byte latched on the rising edge at which i_rx_done=1; the state advances on the same edge.
- Third byte at edge N -> EXEC during cycle N+1 -> o_tx_data updated and o_tx_start high during cycle N+2. Latency from opcode i_rx_done to o_tx_start is 2 cycles.
- i_tx_done at edge M -> WAIT_A in cycle M+1; an i_rx_done at edge M+1 is accepted as operand A.
- i_tx_done arriving while not in WAIT_TX is ignored.
- All outputs are registered, except o_busy, which is decoded from the state register.

## Configuration
- INTERFACE_TIMEOUT_EN defined:
  - A 16-bit counter increments on i_tick while the state is WAIT_B or WAIT_OP.
  - The counter clears on every accepted byte and on entry to WAIT_A.
  - When the count reaches TIMEOUT_TICKS, the next edge goes to WAIT_A, pulses o_error for one cycle and clears the counter; the partial frame is discarded.
  - If i_rx_done and the timeout condition coincide on the same edge, the byte wins: it is accepted and the counter clears.
- INTERFACE_TIMEOUT_EN undefined:
  - No counter is built and i_tick is unused.
  - o_error is constant 0.
  - WAIT_B and WAIT_OP wait indefinitely.

## Structure
- Shared package/header holds:
  - the state encoding constants (3 bits, WAIT_A=0 … WAIT_TX=5);
  - the ALU opcode constants: ADD=6'b100000, SUB=6'b100010, AND=6'b100100, OR=6'b100101, XOR=6'b100110, SRA=6'b000011, SRL=6'b000010, NOR=6'b100111.
- No sub-module is needed. The timeout counter stays inline, inside the INTERFACE_TIMEOUT_EN guard.

## Test plan
- **Basic OR frame.** Reset low 4 cycles, then send bytes 0x05, 0x50, 0x65, with the ALU model driving the OR result:
  - o_alu_data_a=0x05, o_alu_data_b=0x50, o_alu_opcode=6'b100101;
  - o_tx_start pulses 2 cycles after the third i_rx_done, with o_tx_data=0x55.
- **Back-to-back frames.** Frame 1 is 0x03, 0x04, ADD (0x20), then i_tx_done, then frame 2 is 0xFF, 0x01, ADD:
  - o_tx_data=0x07, then 0x00 (8-bit wrap);
  - a byte sent in the cycle right after i_tx_done is accepted as operand A.
- **Bytes during transmission.** i_rx_done with 0xAA while in WAIT_TX -> discarded; the next frame 0x0F, 0xF0, AND (0x24) gives o_tx_data=0x00.
- **Timeout abort (INTERFACE_TIMEOUT_EN, TIMEOUT_TICKS=16).** Send 0x12, then 16 i_tick pulses with no byte:
  - o_error pulses once and the state returns to WAIT_A;
  - a following 0x01, 0x02, SUB (0x22) gives o_tx_data=0xFF.
- **Timeout race.** i_rx_done coincident with the 16th tick in WAIT_B -> byte accepted, no o_error.
- **Mid-frame reset.** Assert reset after the second byte:
  - all outputs are 0 immediately (asynchronous);
  - o_busy=0, and no o_tx_start occurs afterwards.
